panel_keys: RTL
===============

# panel_keys

Front-panel input scanner, the counterpart of the 7-segment display driver. It drives a multiplexed 8×4 key matrix one row at a time and samples the columns through a 2-flop synchronizer. Each key is debounced individually. Outputs are the stable key states, one-cycle press strobes, and the one-hot rotary-switch selector bus (`rotary_bus`) consumed by the display and the control panel logic.

## Interface
- `SCAN_DIV`, default 1000: `clk_sys` cycles per row slot, ≥4.
- `DEBOUNCE`, default 4: consecutive agreeing scans of a row before a key state changes, 1..15.
- `clk_sys` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ROW` out 8: row drive, active-low, exactly one bit low outside reset.
- `COL` in 4: column sense, active-low (pulled up), asynchronous to `clk_sys`.
- `keys` out 32: debounced state; bit r*4+c is row r, column c; 1 = pressed.
- `key_press` out 32: one-cycle strobe on each debounced 0→1 transition.
- `rotary_bus` out 11: one-hot rotary selector position.

## Operation
- Row sequencer:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count, the row index advances 0→1→…→7→0.
  - `ROW` = ~(1 << row index), registered.
- Sampling:
  - `COL` passes through a 2-flop synchronizer.
  - The synchronized value is captured at divider count SCAN_DIV-1. This is at least 3 cycles after the row change, enough for line settle plus synchronizer delay.
  - raw[c] = ~col_sync[c] for the current row.
- Debounce, per key, 4-bit counter:
  - On each sample of the key's row: if raw == `keys` bit, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE, the `keys` bit toggles and the counter clears.
  - Keys in other rows are untouched.
- `key_press`: asserted for exactly the cycle after the `keys` bit goes 0→1. There is no strobe on release.
- Rotary selector, driven by dedicated keys:
  - Key 30 (row 7, col 2) = NEXT; key 31 (row 7, col 3) = PREV.
  - NEXT strobe rotates the one-hot bit up by one; bit 10 wraps to bit 0.
  - PREV strobe rotates it down by one; bit 0 wraps to bit 10.
  - Both strobes in the same cycle: no change.
  - `rotary_bus` is always exactly one-hot.
- Keys 30/31 also appear normally in `keys` and `key_press`.

## Timing
- Reset values:
  - `ROW` = 8'hFE (row 0 driven).
  - divider = 0; synchronizer flops = 4'hF; all debounce counters = 0.
  - `keys` = 0, `key_press` = 0.
  - `rotary_bus` = 11'h001.
- Full scan period: 8·SCAN_DIV cycles.
- Press latency: with `COL` stable before the row's capture point, `keys` sets at the DEBOUNCE-th capture of that row (DEBOUNCE−1 full scans after the first). The capture-to-`keys` update is 1 cycle. `key_press` follows 1 cycle later, and `rotary_bus` updates 1 cycle after the strobe.
- Bounce: any capture disagreeing with the pending change clears the counter, and the count restarts from the next disagreeing capture.
- `rst` mid-scan: all state returns to reset values immediately, with no strobes emitted. Scanning restarts from row 0 after `rst` deasserts.
- Multiple keys in one row may change in the same capture; each is handled independently.

## Test plan
1. Reset, SCAN_DIV=8, DEBOUNCE=2, no keys: `ROW` cycles FE,FD,FB,…,7F, each for 8 cycles. `keys`=0, `key_press`=0, `rotary_bus`=001 throughout.
2. Hold key 5 (row 1, col 1, `COL[1]` low while `ROW[1]` low) continuously: `keys[5]` sets at the 2nd row-1 capture. `key_press[5]` pulses for exactly 1 cycle. After release, `keys[5]` clears after 2 captures, with no strobe.
3. Bounce key 5 on alternate row-1 scans: `keys[5]` never changes and no strobe occurs. Once the key is held steady, it is accepted after 2 captures.
4. NEXT pressed 11 times: `rotary_bus` steps 001→002→…→400→001. A subsequent single PREV press gives 400.
5. NEXT and PREV pressed together (both strobes same cycle): `rotary_bus` unchanged. Both `key_press[30]` and `key_press[31]` pulse.
6. Assert `rst` while a press is half-debounced and `rotary_bus`=010: all outputs return to reset values at once. After release, the still-held key needs a full DEBOUNCE count again.

Source files
------------

// File: rtl/panel_keys.sv
// panel_keys: front-panel key matrix scanner with per-key debounce and a
// one-hot rotary selector driven by two dedicated keys.
//
// Ports:
//   clk_sys    in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   ROW        out  8  active-low row drive, one row low at a time
//   COL        in   4  active-low column sense, asynchronous to clk_sys
//   keys       out 32  debounced key state, bit r*4+c = row r column c
//   key_press  out 32  one-cycle strobe on each debounced press
//   rotary_bus out 11  one-hot rotary selector position
//
// Parameters:
//   SCAN_DIV   clk_sys cycles per row slot (>= 4)
//   DEBOUNCE   consecutive disagreeing captures needed to flip a key (1..15)
module panel_keys #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk_sys,
  input  logic        rst,
  output logic [7:0]  ROW,
  input  logic [3:0]  COL,
  output logic [31:0] keys,
  output logic [31:0] key_press,
  output logic [10:0] rotary_bus
);

  localparam int              DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB      = 4'(DEBOUNCE);
  localparam int              KEY_NEXT = 30;
  localparam int              KEY_PREV = 31;

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    row_q, row_d;
  logic [7:0]    row_n_q, row_n_d;
  logic          capture_s;
  logic [3:0]    sync1_q, sync2_q;
  logic [31:0]   keys_q, keys_d;
  logic [31:0]   keys_dly_q;
  logic [31:0]   press_q, press_d;
  logic [10:0]   rot_q, rot_d;
  logic [3:0]    cnt_q [32];
  logic [3:0]    cnt_d [32];
  logic [3:0]    raw_s;
  logic [4:0]    idx_s;

  // Row sequencer: divider wraps at SCAN_DIV-1, which is also the capture
  // point for the row currently driven; the row advances on the same edge.
  always_comb begin
    div_d     = div_q + DW'(1);
    row_d     = row_q;
    row_n_d   = row_n_q;
    capture_s = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d     = '0;
      row_d     = row_q + 3'd1;
      row_n_d   = ~(8'd1 << row_d);
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Per-key debounce for the four keys of the row being captured.
  always_comb begin
    keys_d = keys_q;
    cnt_d  = cnt_q;
    raw_s  = ~sync2_q;
    idx_s  = 5'd0;
    if (capture_s) begin
      for (int c = 0; c < 4; c++) begin
        idx_s = {row_q, c[1:0]};
        if (raw_s[c] == keys_q[idx_s]) begin
          cnt_d[idx_s] = 4'd0;
        end else if (cnt_q[idx_s] + 4'd1 == DEB) begin
          keys_d[idx_s] = ~keys_q[idx_s];
          cnt_d[idx_s]  = 4'd0;
        end else begin
          cnt_d[idx_s] = cnt_q[idx_s] + 4'd1;
        end
      end
    end else begin
      keys_d = keys_q;
    end
  end

  // Press strobe: rising edges of the debounced state, one cycle late.
  always_comb begin
    press_d = keys_q & ~keys_dly_q;
  end

  // Rotary selector: NEXT rotates up, PREV rotates down, both cancel.
  always_comb begin
    rot_d = rot_q;
    case ({press_q[KEY_NEXT], press_q[KEY_PREV]})
      2'b10:   rot_d = {rot_q[9:0], rot_q[10]};
      2'b01:   rot_d = {rot_q[0], rot_q[10:1]};
      default: rot_d = rot_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      row_q      <= 3'd0;
      row_n_q    <= 8'hFE;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      keys_q     <= 32'd0;
      keys_dly_q <= 32'd0;
      press_q    <= 32'd0;
      rot_q      <= 11'h001;
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= 4'd0;
      end
    end else begin
      div_q      <= div_d;
      row_q      <= row_d;
      row_n_q    <= row_n_d;
      sync1_q    <= COL;
      sync2_q    <= sync1_q;
      keys_q     <= keys_d;
      keys_dly_q <= keys_q;
      press_q    <= press_d;
      rot_q      <= rot_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ROW        = row_n_q;
  assign keys       = keys_q;
  assign key_press  = press_q;
  assign rotary_bus = rot_q;

endmodule
